// File: rtl/cdiv_arb_pkg.sv
// Shared types for the complex_div round-robin arbiter: operand/result bundles,
// divider status flags and the default requester tag type.
package cdiv_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int TAG_W           = $clog2(NUM_REQ_DEFAULT);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [3:0][63:0] operands_t;
  typedef logic [1:0][63:0] result_t;

  // Same bit layout as the FP unit's status flags {NV,DZ,OF,UF,NX}
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdiv_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each divide in flight.
// Head is read combinationally so results route with zero added latency.
module cdiv_tag_fifo
  import cdiv_arb_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type data_t = tag_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  input  logic  push_i,
  input  data_t push_data_i,
  input  logic  pop_i,
  output data_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PW = idx_width(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  data_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      if (push_i && !pop_i)      count <= count + 1'b1;
      else if (pop_i && !push_i) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= push_data_i;
  end

  assign head_o  = mem[rd_ptr];
  // Full comes straight from the count register: a same-cycle pop does not free a slot
  assign full_o  = (count == CNT_FULL);
  assign empty_o = (count == '0);

endmodule

// File: rtl/cdiv_rr_arbiter.sv
// Round-robin issue arbiter sharing one complex_div among NUM_REQ requesters,
// with an in-order tag FIFO steering results back. Optional CDIV_ARB_PERF_EN adds grant counters.
module cdiv_rr_arbiter
  import cdiv_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  operands_t [NUM_REQ-1:0]    req_operands_i,
  input  logic      [NUM_REQ-1:0]    req_valid_i,
  output logic      [NUM_REQ-1:0]    req_ready_o,
  output result_t                    rsp_result_o,
  output status_t                    rsp_status_o,
  output logic      [NUM_REQ-1:0]    rsp_valid_o,
  input  logic      [NUM_REQ-1:0]    rsp_ready_i,
  output operands_t                  div_operands_o,
  output logic                       div_in_valid_o,
  input  logic                       div_in_ready_i,
  input  result_t                    div_result_i,
  input  status_t                    div_status_i,
  input  logic                       div_out_valid_i,
  output logic                       div_out_ready_o,
  input  logic                       flush_i,
  output logic                       div_flush_o,
  output logic                       busy_o
`ifdef CDIV_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]   perf_grants_o
`endif
);

  localparam int IW = idx_width(NUM_REQ);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);

  idx_t rr_ptr;
  idx_t lock_idx;
  idx_t sel_idx;
  idx_t cand;
  idx_t win_idx;
  idx_t head;
  logic lock;
  logic sel_found;
  logic win_valid;
  logic full;
  logic empty;
  logic issue;
  logic pop;

  // Scan downward so the closest valid requester at/after rr_ptr is the last to win
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = idx_t'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign win_idx        = lock ? lock_idx : sel_idx;
  assign win_valid      = lock ? req_valid_i[lock_idx] : sel_found;
  assign div_in_valid_o = win_valid & ~full & ~flush_i;
  assign div_operands_o = req_operands_i[win_idx];
  assign issue          = div_in_valid_o & div_in_ready_i;

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[win_idx] = win_valid & div_in_ready_i & ~full & ~flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (flush_i) begin
      lock <= 1'b0;
    end else if (issue) begin
      lock   <= 1'b0;
      rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end else if (div_in_valid_o) begin
      // Offered but stalled: freeze the choice so operands stay stable
      lock     <= 1'b1;
      lock_idx <= win_idx;
    end
  end

  cdiv_tag_fifo #(
    .DEPTH  (MAX_OUTST),
    .data_t (idx_t)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (issue),
    .push_data_i (win_idx),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // An untagged result is drained so the divider cannot wedge on it
  assign div_out_ready_o = ~flush_i & (empty ? div_out_valid_i : rsp_ready_i[head]);
  assign pop             = div_out_valid_i & div_out_ready_o & ~empty;

  always_comb begin
    rsp_valid_o       = '0;
    rsp_valid_o[head] = div_out_valid_i & ~empty & ~flush_i;
  end

  assign rsp_result_o = div_result_i;
  assign rsp_status_o = div_status_i;
  assign div_flush_o  = flush_i;
  assign busy_o       = ~empty;

  a_no_orphan_result : assert property (@(posedge clk_i) disable iff (rst_i)
    !(div_out_valid_i && empty));

`ifdef CDIV_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] grants;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        grants <= '0;
      end else if (req_valid_i[gi] && req_ready_o[gi] && (grants != '1)) begin
        grants <= grants + 1'b1;
      end
    end
    assign perf_grants_o[gi] = grants;
  end
`endif

endmodule

// File: tb/tb_cdiv_rr_arbiter.sv
// Directed bench for cdiv_rr_arbiter: vector table for round-robin issue and return,
// plus hand sequences for lock, full, back-pressure, flush, reset and CDIV_ARB_PERF_EN counters.
module tb_cdiv_rr_arbiter;
  import cdiv_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  operands_t [3:0] req_operands;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  result_t    rsp_result, div_result;
  status_t    rsp_status, div_status;
  operands_t  div_operands;
  logic div_in_valid, div_in_ready, div_out_valid, div_out_ready, flush, div_flush, busy;
`ifdef CDIV_ARB_PERF_EN
  logic [3:0][31:0] perf_grants;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] valid;
    logic       inr;
    logic       ov;
    logic [3:0] rr;
    logic [3:0] e_rdy;
    logic       e_iv;
    logic [3:0] e_rv;
    logic       e_or;
    logic       e_busy;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  cdiv_rr_arbiter #(.NUM_REQ(4), .MAX_OUTST(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_operands_i  (req_operands),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .rsp_result_o    (rsp_result),
    .rsp_status_o    (rsp_status),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .div_operands_o  (div_operands),
    .div_in_valid_o  (div_in_valid),
    .div_in_ready_i  (div_in_ready),
    .div_result_i    (div_result),
    .div_status_i    (div_status),
    .div_out_valid_i (div_out_valid),
    .div_out_ready_o (div_out_ready),
    .flush_i         (flush),
    .div_flush_o     (div_flush),
    .busy_o          (busy)
`ifdef CDIV_ARB_PERF_EN
    ,
    .perf_grants_o   (perf_grants)
`endif
  );

  function automatic logic [63:0] opw(input int r, input int k);
    return {32'hA5A5_0000 | 32'(r), 32'(k)};
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] v, input logic inr, input logic ov,
                       input logic [3:0] rr, input logic fl);
    req_valid     = v;
    div_in_ready  = inr;
    div_out_valid = ov;
    rsp_ready     = rr;
    flush         = fl;
    #1;
    $display("t=%0t valid=%b in_rdy=%b out_vld=%b rsp_rdy=%b flush=%b -> req_ready=%b in_vld=%b rsp_valid=%b out_rdy=%b busy=%b",
             $time, v, inr, ov, rr, fl, req_ready, div_in_valid, rsp_valid, div_out_ready, busy);
  endtask

  initial begin
    //             valid  inr   ov    rr     e_rdy  e_iv  e_rv   e_or  e_busy
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'hF, 4'h2, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'hF, 4'h4, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'hF, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h0, 1'b1, 1'b1};
    tbl[5]  = '{4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1};
    tbl[6]  = '{4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 4'h2, 1'b1, 1'b1};
    tbl[7]  = '{4'h0, 1'b1, 1'b1, 4'hB, 4'h0, 1'b0, 4'h4, 1'b0, 1'b1};
    tbl[8]  = '{4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 4'h4, 1'b1, 1'b1};
    tbl[9]  = '{4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 4'h8, 1'b1, 1'b1};
    tbl[10] = '{4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1};
    tbl[11] = '{4'h0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) req_operands[r][k] = opw(r, k);
    div_result = '0;
    div_status = 5'b10101;
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;

    chk("reset req_ready", req_ready, 4'h0);
    chk("reset div_in_valid", div_in_valid, 1'b0);
    chk("reset rsp_valid", rsp_valid, 4'h0);
    chk("reset div_out_ready", div_out_ready, 1'b0);
    chk("reset busy", busy, 1'b0);

    // Round-robin issue then in-order return
    for (int i = 0; i < 12; i++) begin
      nxt();
      div_result[0] = 64'(i) + 64'h100;
      drive(tbl[i].valid, tbl[i].inr, tbl[i].ov, tbl[i].rr, 1'b0);
      chk($sformatf("vec%0d req_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d div_in_valid", i), div_in_valid, tbl[i].e_iv);
      chk($sformatf("vec%0d rsp_valid", i), rsp_valid, tbl[i].e_rv);
      chk($sformatf("vec%0d div_out_ready", i), div_out_ready, tbl[i].e_or);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_iv)
        chk($sformatf("vec%0d operands", i), div_operands[3], opw(oh2i(tbl[i].e_rdy), 3));
    end
    chk("result broadcast", rsp_result[0], 64'h10B);
    chk("status broadcast", 64'(rsp_status), 64'h15);

    // Lock: rr_ptr=1, req0 stalled, req1 arrives but must not steal the slot
    nxt(); drive(4'b0001, 1'b0, 1'b0, 4'hF, 1'b0);
    chk("lock c1 in_valid", div_in_valid, 1'b1);
    chk("lock c1 ready", req_ready, 4'h0);
    chk("lock c1 ops", div_operands[0], opw(0, 0));
    for (int c = 2; c <= 3; c++) begin
      nxt(); drive(4'b0011, 1'b0, 1'b0, 4'hF, 1'b0);
      chk($sformatf("lock c%0d ready", c), req_ready, 4'h0);
      chk($sformatf("lock c%0d ops", c), div_operands[0], opw(0, 0));
    end
    nxt(); drive(4'b0011, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("lock c4 grant", req_ready, 4'b0001);
    nxt(); drive(4'b0010, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("lock c5 grant", req_ready, 4'b0010);
    chk("lock c5 ops", div_operands[0], opw(1, 0));
    nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("lock rsp0", rsp_valid, 4'b0001);
    nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("lock rsp1", rsp_valid, 4'b0010);
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("lock idle busy", busy, 1'b0);

    // Full: 8 issues, stall, pop gives a one-cycle bubble before the 9th issue
    for (int i = 0; i < 8; i++) begin
      nxt(); drive(4'b0100, 1'b1, 1'b0, 4'hF, 1'b0);
      chk($sformatf("full issue%0d", i), req_ready, 4'b0100);
    end
    for (int i = 0; i < 2; i++) begin
      nxt(); drive(4'b0100, 1'b1, 1'b0, 4'hF, 1'b0);
      chk($sformatf("full stall%0d ready", i), req_ready, 4'h0);
      chk($sformatf("full stall%0d in_valid", i), div_in_valid, 1'b0);
    end
    nxt(); drive(4'b0100, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("full pop rsp", rsp_valid, 4'b0100);
    chk("full pop bubble", req_ready, 4'h0);
    nxt(); drive(4'b0100, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("full 9th issue", req_ready, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
      chk($sformatf("full drain%0d", i), rsp_valid, 4'b0100);
    end
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("full drained busy", busy, 1'b0);

    // Back-pressure from req2 at the head blocks req3's result behind it
    nxt(); drive(4'b0100, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("bp issue2", req_ready, 4'b0100);
    nxt(); drive(4'b1000, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("bp issue3", req_ready, 4'b1000);
    div_result[0] = 64'hCAFE_0002;
    for (int i = 0; i < 5; i++) begin
      nxt(); drive(4'h0, 1'b1, 1'b1, 4'b1011, 1'b0);
      chk($sformatf("bp stall%0d rsp", i), rsp_valid, 4'b0100);
      chk($sformatf("bp stall%0d out_ready", i), div_out_ready, 1'b0);
    end
    nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("bp release rsp", rsp_valid, 4'b0100);
    chk("bp release out_ready", div_out_ready, 1'b1);
    chk("bp release data", rsp_result[0], 64'hCAFE_0002);
    div_result[0] = 64'hCAFE_0003;
    nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("bp next rsp", rsp_valid, 4'b1000);
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("bp idle busy", busy, 1'b0);

    // Flush with three divides in flight
    for (int i = 0; i < 3; i++) begin
      nxt(); drive(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
      chk($sformatf("flush issue%0d", i), req_ready, 4'(1 << i));
    end
    nxt(); drive(4'hF, 1'b1, 1'b1, 4'hF, 1'b1);
    chk("flush cyc ready", req_ready, 4'h0);
    chk("flush cyc in_valid", div_in_valid, 1'b0);
    chk("flush cyc rsp", rsp_valid, 4'h0);
    chk("flush cyc out_ready", div_out_ready, 1'b0);
    chk("flush cyc div_flush", div_flush, 1'b1);
    nxt(); drive(4'b0010, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("flush after busy", busy, 1'b0);
    chk("flush after grant", req_ready, 4'b0010);
    nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("flush after rsp", rsp_valid, 4'b0010);
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);

    // Asynchronous reset mid-operation (rr_ptr=2 here)
    nxt(); drive(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("rst pre grant", req_ready, 4'b0100);
    nxt(); drive(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("rst pre busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst async busy", busy, 1'b0);
    drive(4'h0, 1'b0, 1'b0, 4'hF, 1'b0);
    nxt(); rst = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("rst rr_ptr cleared", req_ready, 4'b0001);
    nxt(); drive(4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
    chk("rst post rsp", rsp_valid, 4'b0001);
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);

`ifdef CDIV_ARB_PERF_EN
    for (int i = 0; i < 5; i++) begin
      nxt(); drive(4'b1000, 1'b1, 1'b0, 4'hF, 1'b0);
    end
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("perf req3 grants", perf_grants[3], 32'd5);
    chk("perf req0 grants", perf_grants[0], 32'd1);
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b1);
    nxt(); drive(4'h0, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("perf after flush", perf_grants[3], 32'd5);
    chk("perf flush busy", busy, 1'b0);
    rst = 1'b1;
    #1;
    chk("perf after reset", perf_grants[3], 32'd0);
    nxt(); rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
